cipher_block_arbiter: RTL and testbench
=======================================

// Module: cipher_block_arbiter
// PURPOSE
//  Shares one block decryptor among NUM_CH symbol-deserializer channels.
//  Round-robin picks one pending cipher block and forwards it with its channel id.
//  Holds each forwarded block until the decryptor accepts it.
//  Watches for decryptor stalls and keeps per-run statistics.
//  Sits between the deserializer bank and the decryptor.
// PARAMETERS
//  NUM_CH    4      number of requesting deserializer channels (2..8)
//  BLOCK_W   128    cipher block width in bits
//  ID_W      2      channel id width; must equal clog2(NUM_CH)
//  STALL_MAX 1024   cycles dec_valid may wait on dec_ready before stall_err
// PORTS
//  clk        in   1              system clock, rising edge
//  reset      in   1              synchronous, active-high reset
//  enable     in   1              1 = grants allowed; 0 = no new grants (current hold completes)
//  flush      in   1              1-cycle pulse: drop held block, clear stall, return to IDLE
//  ch_block   in   NUM_CH*BLOCK_W channel i block at [i*BLOCK_W +: BLOCK_W]
//  ch_valid   in   NUM_CH         channel i has a block pending
//  ch_ready   out  NUM_CH         one-hot accept pulse to the granted channel
//  dec_block  out  BLOCK_W        block presented to the decryptor
//  dec_ch_id  out  ID_W           source channel of dec_block
//  dec_valid  out  1              dec_block/dec_ch_id valid
//  dec_ready  in   1              decryptor accepts when dec_valid & dec_ready
//  stall_err  out  1              sticky; STALL_MAX reached in HOLD
//  grant_cnt  out  16             blocks accepted by the decryptor since reset/flush; wraps
// BEHAVIOUR
//  Reset values
//   - All outputs 0.
//   - rr_ptr = 0, state = IDLE, stall counter = 0.
//  Handshake
//   - Transfer occurs when dec_valid & dec_ready.
//   - Upstream transfer occurs when ch_ready[i] & ch_valid[i].
//  Output stability
//   - dec_block and dec_ch_id are registered.
//   - They stay stable while dec_valid is high and dec_ready is low.
//  Grant selection
//   - Search starts at rr_ptr and wraps NUM_CH-1 -> 0.
//   - The first channel with ch_valid set wins.
//  ch_ready (combinational)
//   - High only for the winner.
//   - Requires: enable, !flush, state != STALL, and (state==IDLE or a transfer this cycle).
//  Capture
//   - On the ch_ready cycle, the winning block and id load into the output registers.
//   - dec_valid = 1 from the next cycle; latency 1 clk.
//   - rr_ptr <= winner + 1, modulo NUM_CH.
//  States
//   - IDLE:  dec_valid = 0. Capture -> HOLD.
//   - HOLD:  dec_valid = 1.
//       - Transfer and new capture in the same cycle -> stay in HOLD (back-to-back, 1 block/clk).
//       - Transfer with no capture -> IDLE.
//       - Stall counter +1 per cycle with !dec_ready; cleared on transfer.
//       - Counter reaches STALL_MAX-1 -> STALL.
//   - STALL: stall_err = 1. dec_valid stays 1; no grants.
//       - Transfer -> IDLE; stall_err stays set.
//       - flush -> IDLE.
//  flush (any state, highest priority after reset)
//   - dec_valid <= 0, state <= IDLE, stall_err <= 0, grant_cnt <= 0.
//   - No ch_ready that cycle.
//   - rr_ptr is kept.
//  enable = 0
//   - Blocks new grants only.
//   - A held block still completes its transfer.
//  Other rules
//   - grant_cnt += 1 per transfer; FFFF wraps to 0000.
//   - Single-channel case: the same channel is re-granted every cycle if valid (fairness is trivial).
//   - ch_valid dropping mid-cycle: no obligation; selection uses the current-cycle ch_valid.
//   - Reset mid-hold: the held block is discarded; upstream keeps its own block.
// STRUCTURE
//  Shared package zmodem_pkg:
//   - state encoding (IDLE=2'd0, HOLD=2'd1, STALL=2'd2)
//   - CIPHER_BLOCK_W = 128
//  One sub-module: rr_pick
//   - Pure combinational round-robin priority encoder.
//   - Inputs: req[NUM_CH], ptr.
//   - Outputs: gnt one-hot, gnt_id, any.
//  The top level holds the FSM, output registers, stall counter and grant_cnt.
// TESTING
//  1. Reset, ch_valid=0001, block=0x0011..FF, dec_ready=1
//     -> ch_ready=0001 in cycle 0; dec_valid, dec_ch_id=0, block match in cycle 1; grant_cnt=1.
//  2. ch_valid=1111 held high, dec_ready=1
//     -> grant order 0,1,2,3,0 in consecutive cycles; dec_valid continuously 1.
//  3. Grant ch2, dec_ready=0 for 5 cycles
//     -> dec_block stable; ch_ready=0000 throughout; transfer on first dec_ready=1 cycle.
//  4. STALL_MAX=8, dec_ready=0
//     -> stall_err=1 after 8 HOLD cycles; no ch_ready; flush -> dec_valid=0, stall_err=0, state IDLE.
//  5. enable=0 with ch_valid=0110
//     -> no ch_ready; set enable=1 -> ch1 granted first (rr_ptr=0 after reset).
//  6. Preload grant_cnt to FFFF with 65535 transfers, then 1 more
//     -> grant_cnt=0000; reset mid-HOLD -> all outputs 0 next cycle.

Source files
------------

// File: rtl/zmodem_pkg.sv
// Shared definitions for the cipher block arbiter: FSM states and block width.
package zmodem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    STALL = 2'd2
  } arb_state_e;

  localparam int CIPHER_BLOCK_W = 128;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority encoder: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int NUM_CH = 4,
  parameter int ID_W   = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [ID_W-1:0]   ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [ID_W-1:0]   gnt_id,
  output logic              any
);

  // Walk the offsets from ptr in priority order; the first requester wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (!any && req[c] && (((32'(ptr) + k) % NUM_CH) == c)) begin
          gnt[c] = 1'b1;
          gnt_id = ID_W'(c);
          any    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cipher_block_arbiter.sv
// Shares one block decryptor among NUM_CH deserializer channels with
// round-robin grants, hold-until-accept output registers, stall detection
// and a transfer counter.
module cipher_block_arbiter
  import zmodem_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int BLOCK_W   = CIPHER_BLOCK_W,
  parameter int ID_W      = 2,
  parameter int STALL_MAX = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      flush,
  input  logic [NUM_CH*BLOCK_W-1:0] ch_block,
  input  logic [NUM_CH-1:0]         ch_valid,
  output logic [NUM_CH-1:0]         ch_ready,
  output logic [BLOCK_W-1:0]        dec_block,
  output logic [ID_W-1:0]           dec_ch_id,
  output logic                      dec_valid,
  input  logic                      dec_ready,
  output logic                      stall_err,
  output logic [15:0]               grant_cnt
);

  localparam int CNT_W = (STALL_MAX > 2) ? $clog2(STALL_MAX) : 1;

  arb_state_e          state, state_next;
  logic [ID_W-1:0]     rr_ptr;
  logic [CNT_W-1:0]    stall_cnt;
  logic [NUM_CH-1:0]   gnt;
  logic [ID_W-1:0]     gnt_id;
  logic                any;
  logic                xfer;
  logic                capture;
  logic [BLOCK_W-1:0]  sel_block;

  assign xfer = dec_valid & dec_ready;

  rr_pick #(
    .NUM_CH (NUM_CH),
    .ID_W   (ID_W)
  ) u_pick (
    .req    (ch_valid),
    .ptr    (rr_ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (any)
  );

  // Winning channel's block, selected from the flat input bus.
  always_comb begin
    sel_block = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) sel_block = ch_block[i*BLOCK_W +: BLOCK_W];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Grant qualification and next-state logic. A grant in HOLD is only
  // allowed on a transfer cycle so the output register is free to reload.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    ch_ready   = '0;
    if (!reset && enable && !flush && any &&
        (state == IDLE || (state == HOLD && xfer))) begin
      capture  = 1'b1;
      ch_ready = gnt;
    end
    if (flush) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (capture) state_next = HOLD;
        HOLD: begin
          if (xfer)                                     state_next = capture ? HOLD : IDLE;
          else if (stall_cnt == CNT_W'(STALL_MAX - 1))  state_next = STALL;
        end
        STALL:   if (xfer) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Stall counter: counts consecutive unaccepted HOLD cycles.
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (state == HOLD && state_next == HOLD && !dec_ready)
      stall_cnt <= stall_cnt + 1'b1;
    else
      stall_cnt <= '0;
  end

  // Output registers, round-robin pointer, sticky stall flag, transfer count.
  always_ff @(posedge clk) begin
    if (reset) begin
      dec_block <= '0;
      dec_ch_id <= '0;
      dec_valid <= 1'b0;
      stall_err <= 1'b0;
      grant_cnt <= '0;
      rr_ptr    <= '0;
    end else begin
      dec_valid <= (state_next != IDLE);
      if (flush) begin
        stall_err <= 1'b0;
        grant_cnt <= '0;
      end else begin
        if (xfer) grant_cnt <= grant_cnt + 16'd1;
        if (state == HOLD && state_next == STALL) stall_err <= 1'b1;
        if (capture) begin
          dec_block <= sel_block;
          dec_ch_id <= gnt_id;
          rr_ptr    <= (gnt_id == ID_W'(NUM_CH - 1)) ? '0 : gnt_id + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cipher_block_arbiter.sv
// Self-checking bench: hand-derived vector table, directed corner sequences,
// and randomized traffic, all compared against a transaction-level model.
module tb_cipher_block_arbiter;

  localparam int NUM_CH    = 4;
  localparam int BLOCK_W   = 128;
  localparam int ID_W      = 2;
  localparam int STALL_MAX = 8;
  localparam logic [127:0] BLK0 = 128'h00112233445566778899AABBCCDDEEFF;

  logic                      clk = 1'b0;
  logic                      reset, enable, flush, dec_ready;
  logic [NUM_CH-1:0]         ch_valid;
  logic [NUM_CH*BLOCK_W-1:0] ch_block;
  logic [NUM_CH-1:0]         ch_ready;
  logic [BLOCK_W-1:0]        dec_block;
  logic [ID_W-1:0]           dec_ch_id;
  logic                      dec_valid, stall_err;
  logic [15:0]               grant_cnt;
  logic [127:0]              blk [NUM_CH];

  assign ch_block = {blk[3], blk[2], blk[1], blk[0]};

  always #5 clk = ~clk;

  cipher_block_arbiter #(
    .NUM_CH    (NUM_CH),
    .BLOCK_W   (BLOCK_W),
    .ID_W      (ID_W),
    .STALL_MAX (STALL_MAX)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .flush     (flush),
    .ch_block  (ch_block),
    .ch_valid  (ch_valid),
    .ch_ready  (ch_ready),
    .dec_block (dec_block),
    .dec_ch_id (dec_ch_id),
    .dec_valid (dec_valid),
    .dec_ready (dec_ready),
    .stall_err (stall_err),
    .grant_cnt (grant_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a held block (or none), the next channel to
  // favour, how long the held block has waited, and the statistics.
  bit           m_known = 0;
  bit           m_valid, m_stall, m_serr;
  logic [127:0] m_block;
  int           m_id, m_ptr, m_wait;
  logic [15:0]  m_cnt;

  function automatic int winner();
    if (reset || !enable || flush || m_stall || (m_valid && !dec_ready)) return -1;
    for (int k = 0; k < NUM_CH; k++) begin
      int c;
      c = (m_ptr + k) % NUM_CH;
      if (ch_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic settle_and_check();
    int w;
    #1;
    if (m_known) begin
      w = winner();
      chk("mdl_ch_ready",  ch_ready, (w >= 0) ? (4'b0001 << w) : 4'b0000);
      chk("mdl_dec_valid", dec_valid, m_valid);
      chk("mdl_dec_block", dec_block, m_block);
      chk("mdl_dec_ch_id", dec_ch_id, 128'(m_id));
      chk("mdl_stall_err", stall_err, m_serr);
      chk("mdl_grant_cnt", grant_cnt, m_cnt);
    end
  endtask

  task automatic advance();
    int w;
    w = winner();
    if (reset) begin
      m_known = 1; m_valid = 0; m_stall = 0; m_serr = 0;
      m_block = '0; m_id = 0; m_ptr = 0; m_wait = 0; m_cnt = '0;
    end else if (flush) begin
      m_valid = 0; m_stall = 0; m_serr = 0; m_wait = 0; m_cnt = '0;
    end else begin
      if (m_valid && dec_ready) begin
        m_cnt++; m_valid = 0; m_stall = 0; m_wait = 0;
      end else if (m_valid && !m_stall) begin
        m_wait++;
        if (m_wait == STALL_MAX) begin
          m_stall = 1; m_serr = 1; m_wait = 0;
        end
      end
      if (w >= 0) begin
        m_valid = 1; m_block = blk[w]; m_id = w; m_ptr = (w + 1) % NUM_CH;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_blocks();
    for (int i = 0; i < NUM_CH; i++) blk[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic do_reset();
    reset = 1; enable = 1; flush = 0; ch_valid = '0; dec_ready = 0;
    settle_and_check();
    advance();
    reset = 0;
  endtask

  typedef struct {
    bit         rst, en, fl;
    logic [3:0] v;
    bit         rdy;
    logic [3:0] e_rdy;
    bit         e_dv;
    logic [1:0] e_id;
    logic [15:0] e_gc;
  } vec_t;

  vec_t tbl [24];

  initial begin
    logic [127:0] held;

    //            rst en fl v        rdy e_rdy    dv id     gc
    tbl[0]  = '{0, 1, 0, 4'b0001, 1, 4'b0001, 0, 2'd0, 16'd0};
    tbl[1]  = '{0, 1, 0, 4'b0000, 1, 4'b0000, 1, 2'd0, 16'd0};
    tbl[2]  = '{0, 1, 0, 4'b0000, 1, 4'b0000, 0, 2'd0, 16'd1};
    tbl[3]  = '{1, 1, 0, 4'b0000, 1, 4'b0000, 0, 2'd0, 16'd1};
    tbl[4]  = '{0, 1, 0, 4'b1111, 1, 4'b0001, 0, 2'd0, 16'd0};
    tbl[5]  = '{0, 1, 0, 4'b1111, 1, 4'b0010, 1, 2'd0, 16'd0};
    tbl[6]  = '{0, 1, 0, 4'b1111, 1, 4'b0100, 1, 2'd1, 16'd1};
    tbl[7]  = '{0, 1, 0, 4'b1111, 1, 4'b1000, 1, 2'd2, 16'd2};
    tbl[8]  = '{0, 1, 0, 4'b1111, 1, 4'b0001, 1, 2'd3, 16'd3};
    tbl[9]  = '{0, 1, 0, 4'b0000, 1, 4'b0000, 1, 2'd0, 16'd4};
    tbl[10] = '{0, 1, 0, 4'b0000, 1, 4'b0000, 0, 2'd0, 16'd5};
    tbl[11] = '{1, 1, 0, 4'b0000, 1, 4'b0000, 0, 2'd0, 16'd5};
    tbl[12] = '{0, 0, 0, 4'b0110, 1, 4'b0000, 0, 2'd0, 16'd0};
    tbl[13] = '{0, 0, 0, 4'b0110, 1, 4'b0000, 0, 2'd0, 16'd0};
    tbl[14] = '{0, 1, 0, 4'b0110, 1, 4'b0010, 0, 2'd0, 16'd0};
    tbl[15] = '{0, 1, 0, 4'b0110, 0, 4'b0000, 1, 2'd1, 16'd0};
    tbl[16] = '{0, 0, 0, 4'b0110, 1, 4'b0000, 1, 2'd1, 16'd0};
    tbl[17] = '{0, 1, 0, 4'b0110, 1, 4'b0100, 0, 2'd1, 16'd1};
    tbl[18] = '{0, 1, 0, 4'b0000, 1, 4'b0000, 1, 2'd2, 16'd1};
    tbl[19] = '{0, 1, 0, 4'b0000, 1, 4'b0000, 0, 2'd2, 16'd2};
    tbl[20] = '{0, 1, 1, 4'b0001, 1, 4'b0000, 0, 2'd2, 16'd2};
    tbl[21] = '{0, 1, 0, 4'b0001, 1, 4'b0001, 0, 2'd2, 16'd0};
    tbl[22] = '{0, 1, 0, 4'b0000, 1, 4'b0000, 1, 2'd0, 16'd0};
    tbl[23] = '{0, 1, 0, 4'b0000, 1, 4'b0000, 0, 2'd0, 16'd1};

    for (int i = 0; i < NUM_CH; i++) blk[i] = BLK0 + 128'(i);
    reset = 1; enable = 0; flush = 0; ch_valid = '0; dec_ready = 0;
    #1;
    advance();
    do_reset();

    // Vector table: reset, round-robin order, enable gating, flush.
    for (int i = 0; i < 24; i++) begin
      reset = tbl[i].rst; enable = tbl[i].en; flush = tbl[i].fl;
      ch_valid = tbl[i].v; dec_ready = tbl[i].rdy;
      settle_and_check();
      chk($sformatf("tbl%0d_ch_ready", i),  ch_ready,  tbl[i].e_rdy);
      chk($sformatf("tbl%0d_dec_valid", i), dec_valid, tbl[i].e_dv);
      chk($sformatf("tbl%0d_dec_ch_id", i), dec_ch_id, tbl[i].e_id);
      chk($sformatf("tbl%0d_grant_cnt", i), grant_cnt, tbl[i].e_gc);
      if (i == 1) chk("tbl1_dec_block", dec_block, BLK0);
      advance();
    end

    // Held block stays stable while the decryptor is not ready.
    do_reset();
    ch_valid = 4'b0100;
    settle_and_check();
    chk("hold_grant", ch_ready, 4'b0100);
    held = blk[2];
    advance();
    ch_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      rand_blocks();
      settle_and_check();
      chk("hold_ch_ready", ch_ready, 4'b0000);
      chk("hold_block", dec_block, held);
      chk("hold_valid", dec_valid, 1'b1);
      advance();
    end
    dec_ready = 1;
    settle_and_check();
    chk("hold_release_grant", ch_ready, 4'b1000);
    advance();
    ch_valid = '0;
    settle_and_check();
    chk("hold_release_cnt", grant_cnt, 16'd1);
    chk("hold_release_id", dec_ch_id, 2'd3);
    advance();

    // Stall detection, exit by transfer (sticky flag), then exit by flush.
    do_reset();
    ch_valid = 4'b0001;
    settle_and_check();
    advance();
    ch_valid = 4'b1111;
    for (int i = 0; i < STALL_MAX; i++) begin
      settle_and_check();
      chk("stall_pre_err", stall_err, 1'b0);
      chk("stall_pre_valid", dec_valid, 1'b1);
      chk("stall_pre_ready", ch_ready, 4'b0000);
      advance();
    end
    settle_and_check();
    chk("stall_err_set", stall_err, 1'b1);
    chk("stall_valid", dec_valid, 1'b1);
    advance();
    dec_ready = 1;
    settle_and_check();
    chk("stall_no_grant_on_xfer", ch_ready, 4'b0000);
    advance();
    ch_valid = '0;
    settle_and_check();
    chk("stall_exit_valid", dec_valid, 1'b0);
    chk("stall_exit_sticky", stall_err, 1'b1);
    chk("stall_exit_cnt", grant_cnt, 16'd1);
    dec_ready = 0;
    ch_valid = 4'b0010;
    advance();
    ch_valid = 4'b1111;
    for (int i = 0; i < STALL_MAX; i++) begin
      settle_and_check();
      advance();
    end
    settle_and_check();
    chk("stall2_err_set", stall_err, 1'b1);
    flush = 1;
    settle_and_check();
    chk("flush_no_grant", ch_ready, 4'b0000);
    advance();
    flush = 0; ch_valid = '0;
    settle_and_check();
    chk("flush_valid", dec_valid, 1'b0);
    chk("flush_err", stall_err, 1'b0);
    chk("flush_cnt", grant_cnt, 16'd0);
    advance();

    // Counter wrap, then reset in the middle of a hold.
    do_reset();
    ch_valid = 4'b1111; dec_ready = 1;
    for (int i = 0; i < 65536; i++) begin
      settle_and_check();
      advance();
    end
    settle_and_check();
    chk("wrap_ffff", grant_cnt, 16'hFFFF);
    advance();
    dec_ready = 0;
    settle_and_check();
    chk("wrap_zero", grant_cnt, 16'h0000);
    chk("wrap_holding", dec_valid, 1'b1);
    advance();
    reset = 1;
    settle_and_check();
    advance();
    reset = 0; ch_valid = '0;
    settle_and_check();
    chk("midhold_rst_valid", dec_valid, 1'b0);
    chk("midhold_rst_block", dec_block, 128'd0);
    chk("midhold_rst_id", dec_ch_id, 2'd0);
    chk("midhold_rst_err", stall_err, 1'b0);
    chk("midhold_rst_cnt", grant_cnt, 16'd0);
    chk("midhold_rst_ready", ch_ready, 4'b0000);
    advance();

    // Randomized traffic with periodic long decryptor stalls.
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 299) == 0);
      enable    = ($urandom_range(0, 9) != 0);
      flush     = ($urandom_range(0, 59) == 0);
      ch_valid  = 4'($urandom);
      dec_ready = ((i % 200) < 30) ? 1'b0 : ($urandom_range(0, 3) != 0);
      rand_blocks();
      settle_and_check();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
